// File: rtl/module_hamming_encoder_tx.sv
// Hamming(7,4) encoder with optional single-bit error injection and an
// LSB-first serial framer (start bit, 7 payload bits, stop bit).
// Each serial bit lasts CLKS_PER_BIT clock cycles. A nibble is accepted
// over a valid/ready handshake, and only while the framer is idle.

module module_hamming_encoder_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic [2:0] err_pos,
    output logic [6:0] codeword,
    output logic       tx_serial,
    output logic       tx_busy,
    output logic       tx_done
);

    // The baud counter is at least one bit wide, so CLKS_PER_BIT=1 still elaborates.
    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        LAST_BIT  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [BAUD_W-1:0] baud_reg, baud_next;
    logic [2:0]        bit_idx_reg, bit_idx_next;
    logic [6:0]        codeword_reg, codeword_next;
    logic              done_reg, done_next;

    logic [6:0]        clean_word;
    logic [6:0]        err_mask;
    logic              transfer;
    logic              baud_tick;

    // Codeword layout, MSB..LSB: {i3, i2, i1, p3, i0, p2, p1}.
    // The parity bits sit at Hamming positions 1, 2 and 4, so a decoder
    // syndrome directly names the position of a flipped bit.
    assign clean_word = {
        data_in[3],
        data_in[2],
        data_in[1],
        data_in[1] ^ data_in[2] ^ data_in[3],
        data_in[0],
        data_in[0] ^ data_in[2] ^ data_in[3],
        data_in[0] ^ data_in[1] ^ data_in[3]
    };

    // One-hot flip mask. err_pos=0 matches no bit, so that value means no injection.
    // err_pos values 1..7 each select exactly one bit, so at most one bit is ever flipped.
    generate
        for (genvar gi = 0; gi < 7; gi++) begin : g_err_mask
            assign err_mask[gi] = (err_pos == 3'(gi + 1));
        end
    endgenerate

    assign data_ready = (state_reg == S_IDLE);
    assign transfer   = data_valid && data_ready;
    assign baud_tick  = (baud_reg == BAUD_LAST);

    // State, counter, payload and done registers; reset wins over any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            baud_reg     <= '0;
            bit_idx_reg  <= '0;
            codeword_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_idx_reg  <= bit_idx_next;
            codeword_reg <= codeword_next;
            done_reg     <= done_next;
        end
    end

    // Next-state logic: walk START -> DATA (7 bits) -> STOP, one baud period per bit.
    always_comb begin
        state_next    = state_reg;
        baud_next     = baud_reg;
        bit_idx_next  = bit_idx_reg;
        codeword_next = codeword_reg;
        done_next     = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (transfer) begin
                    state_next    = S_START;
                    baud_next     = '0;
                    bit_idx_next  = '0;
                    codeword_next = clean_word ^ err_mask;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    state_next = S_DATA;
                    baud_next  = '0;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    baud_next = '0;
                    // The bit index stops at 6 and never wraps; STOP takes over from here.
                    if (bit_idx_reg == LAST_BIT) begin
                        state_next = S_STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 1'b1;
                    end
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    state_next = S_IDLE;
                    baud_next  = '0;
                    done_next  = 1'b1;
                end else begin
                    baud_next = baud_reg + 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Line driver: the line idles high, the start bit is low, then payload bits go LSB first.
    always_comb begin
        tx_serial = 1'b1;
        case (state_reg)
            S_START: tx_serial = 1'b0;
            S_DATA:  tx_serial = codeword_reg[bit_idx_reg];
            default: tx_serial = 1'b1;
        endcase
    end

    assign tx_busy  = (state_reg != S_IDLE);
    assign tx_done  = done_reg;
    assign codeword = codeword_reg;

endmodule

// File: tb/tb_module_hamming_encoder_tx.sv
// Bench for the Hamming(7,4) serial transmitter.
// Two instances run side by side, one with 4-cycle bits and one with 1-cycle bits.
// A frame-level model predicts every output in every cycle. The bench also
// applies a table of known codewords, a syndrome sweep, back-to-back frames,
// resets during a frame and random traffic.

module tb_module_hamming_encoder_tx;

    localparam int C0 = 4;
    localparam int C1 = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [3:0] din  [2];
    logic       dv   [2];
    logic [2:0] ep   [2];
    logic       dr   [2];
    logic [6:0] cw   [2];
    logic       ser  [2];
    logic       busy [2];
    logic       done [2];

    module_hamming_encoder_tx #(.CLKS_PER_BIT(C0)) dut4 (
        .clk(clk), .rst(rst), .data_in(din[0]), .data_valid(dv[0]),
        .data_ready(dr[0]), .err_pos(ep[0]), .codeword(cw[0]),
        .tx_serial(ser[0]), .tx_busy(busy[0]), .tx_done(done[0])
    );

    module_hamming_encoder_tx #(.CLKS_PER_BIT(C1)) dut1 (
        .clk(clk), .rst(rst), .data_in(din[1]), .data_valid(dv[1]),
        .data_ready(dr[1]), .err_pos(ep[1]), .codeword(cw[1]),
        .tx_serial(ser[1]), .tx_busy(busy[1]), .tx_done(done[1])
    );

    int total = 0;
    int bad   = 0;

    // Model state for each instance.
    // rem is the number of frame cycles left, counting the current one; 0 means idle.
    int         cpb    [2] = '{C0, C1};
    int         rem    [2] = '{0, 0};
    logic [6:0] m_cw   [2] = '{7'd0, 7'd0};
    logic       m_done [2] = '{1'b0, 1'b0};

    typedef struct packed {
        logic [3:0] d;
        logic [2:0] e;
        logic [6:0] cw;
    } vec_t;

    // Generic Hamming rule: data bits go to the non-power-of-two positions 3, 5, 6, 7.
    // Parity bit k covers every position whose index has bit k set.
    function automatic logic [6:0] encode(input logic [3:0] d, input logic [2:0] e);
        logic [6:0] w;
        logic       par;
        w    = '0;
        w[2] = d[0];
        w[4] = d[1];
        w[5] = d[2];
        w[6] = d[3];
        for (int b = 0; b < 3; b++) begin
            par = 1'b0;
            for (int pos = 1; pos <= 7; pos++) begin
                if (pos[b] && (pos != (1 << b))) par = par ^ w[pos-1];
            end
            w[(1 << b) - 1] = par;
        end
        if (e != 0) w[e-1] = ~w[e-1];
        return w;
    endfunction

    function automatic logic [2:0] syndrome(input logic [6:0] w);
        int s;
        s = 0;
        for (int k = 0; k < 7; k++) if (w[k]) s = s ^ (k + 1);
        return 3'(s);
    endfunction

    function automatic logic [3:0] correct(input logic [6:0] w);
        logic [6:0] c;
        logic [2:0] s;
        c = w;
        s = syndrome(w);
        if (s != 0) c[s-1] = ~c[s-1];
        return {c[6], c[5], c[4], c[2]};
    endfunction

    // Expected line level: the frame is 9 slots (0, payload LSB first, 1), each cpb cycles long.
    function automatic logic exp_line(input int d);
        int slot;
        if (rem[d] == 0) return 1'b1;
        slot = (9 * cpb[d] - rem[d]) / cpb[d];
        if (slot == 0) return 1'b0;
        if (slot == 8) return 1'b1;
        return m_cw[d][slot-1];
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock: update the model at the rising edge, then compare every output at the falling edge.
    task automatic step();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                rem[d]    = 0;
                m_cw[d]   = '0;
                m_done[d] = 1'b0;
            end else begin
                m_done[d] = (rem[d] == 1);
                if (rem[d] > 0) begin
                    rem[d]--;
                end else if (dv[d]) begin
                    rem[d]  = 9 * cpb[d];
                    m_cw[d] = encode(din[d], ep[d]);
                    $display("xfer cpb=%0d data=%b err=%0d codeword=%b", cpb[d], din[d], ep[d], m_cw[d]);
                end
            end
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("cpb%0d tx_serial", cpb[d]), int'(ser[d]), int'(exp_line(d)));
            chk($sformatf("cpb%0d tx_busy", cpb[d]), int'(busy[d]), int'(rem[d] != 0));
            chk($sformatf("cpb%0d data_ready", cpb[d]), int'(dr[d]), int'(rem[d] == 0));
            chk($sformatf("cpb%0d tx_done", cpb[d]), int'(done[d]), int'(m_done[d]));
            chk($sformatf("cpb%0d codeword", cpb[d]), int'(cw[d]), int'(m_cw[d]));
        end
    endtask

    initial begin
        vec_t vecs [7];
        int   k;
        int   ndone;
        int   run    [2];
        int   frames [2];
        logic want_busy [2];

        vecs[0] = '{4'b1011, 3'd0, 7'b1010101};
        vecs[1] = '{4'b0000, 3'd0, 7'b0000000};
        vecs[2] = '{4'b0001, 3'd0, 7'b0000111};
        vecs[3] = '{4'b1111, 3'd0, 7'b1111111};
        vecs[4] = '{4'b1011, 3'd3, 7'b1010001};
        vecs[5] = '{4'b0110, 3'd0, 7'b0110011};
        vecs[6] = '{4'b1000, 3'd7, 7'b0001011};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            din[d] = '0;
            dv[d]  = 1'b0;
            ep[d]  = '0;
        end
        step();
        step();
        chk("reset tx_serial", int'(ser[0]), 1);
        chk("reset tx_busy", int'(busy[0]), 0);
        chk("reset data_ready", int'(dr[0]), 1);
        chk("reset codeword", int'(cw[0]), 0);
        rst = 1'b0;

        // Known codewords and frame timing on the 4-cycle instance.
        for (int i = 0; i < 7; i++) begin
            din[0] = vecs[i].d;
            ep[0]  = vecs[i].e;
            dv[0]  = 1'b1;
            step();
            dv[0]  = 1'b0;
            din[0] = ~vecs[i].d;
            ep[0]  = 3'd5;
            chk($sformatf("table %0d codeword", i), int'(cw[0]), int'(vecs[i].cw));
            chk($sformatf("table %0d syndrome", i), int'(syndrome(cw[0])), int'(vecs[i].e));
            chk($sformatf("table %0d corrected", i), int'(correct(cw[0])), int'(vecs[i].d));
            k = 1;
            while (!done[0] && k < 80) begin
                step();
                k++;
            end
            chk($sformatf("table %0d done latency", i), k, 37);
        end

        // Reset while DATA bit 3 is on the line aborts the frame.
        din[0] = 4'b1011;
        ep[0]  = 3'd0;
        dv[0]  = 1'b1;
        step();
        dv[0] = 1'b0;
        for (int c = 2; c <= 18; c++) step();
        chk("pre-reset bit3 line", int'(ser[0]), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort tx_serial", int'(ser[0]), 1);
        chk("abort tx_busy", int'(busy[0]), 0);
        chk("abort codeword", int'(cw[0]), 0);
        ndone = 0;
        for (int c = 0; c < 40; c++) begin
            step();
            ndone += int'(done[0]);
        end
        chk("abort no tx_done", ndone, 0);
        din[0] = 4'b0110;
        dv[0]  = 1'b1;
        step();
        dv[0] = 1'b0;
        chk("after abort codeword", int'(cw[0]), int'(7'b0110011));
        k = 1;
        while (!done[0] && k < 80) begin
            step();
            k++;
        end
        chk("after abort done latency", k, 37);

        // Reset takes priority over a transfer in the same cycle.
        rst    = 1'b1;
        din[0] = 4'b1111;
        dv[0]  = 1'b1;
        step();
        rst   = 1'b0;
        dv[0] = 1'b0;
        chk("rst+xfer tx_busy", int'(busy[0]), 0);
        chk("rst+xfer codeword", int'(cw[0]), 0);
        step();
        chk("rst+xfer still idle", int'(busy[0]), 0);

        // Back-to-back frames: valid held high, data toggling every cycle.
        for (int d = 0; d < 2; d++) begin
            run[d]       = 0;
            frames[d]    = 0;
            want_busy[d] = 1'b0;
            dv[d]        = 1'b1;
        end
        for (int c = 0; c < 130; c++) begin
            for (int d = 0; d < 2; d++) din[d] = c[0] ? 4'b0101 : 4'b1010;
            step();
            for (int d = 0; d < 2; d++) begin
                if (want_busy[d]) begin
                    chk($sformatf("b2b cpb%0d restart", cpb[d]), int'(busy[d]), 1);
                    want_busy[d] = 1'b0;
                end
                if (busy[d]) run[d]++;
                if (done[d]) begin
                    chk($sformatf("b2b cpb%0d frame length", cpb[d]), run[d], 9 * cpb[d]);
                    run[d]       = 0;
                    frames[d]++;
                    want_busy[d] = 1'b1;
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("b2b cpb%0d frames seen", cpb[d]), int'(frames[d] >= 3), 1);
            dv[d] = 1'b0;
        end
        for (int c = 0; c < 40; c++) step();

        // Syndrome sweep on the 1-cycle instance: every nibble with every injection position.
        for (int n = 0; n < 16; n++) begin
            for (int e = 0; e < 8; e++) begin
                din[1] = 4'(n);
                ep[1]  = 3'(e);
                dv[1]  = 1'b1;
                step();
                dv[1] = 1'b0;
                chk($sformatf("sweep %0d/%0d flipped bits", n, e),
                    $countones(cw[1] ^ encode(4'(n), 3'd0)), int'(e != 0));
                chk($sformatf("sweep %0d/%0d syndrome", n, e), int'(syndrome(cw[1])), e);
                chk($sformatf("sweep %0d/%0d corrected", n, e), int'(correct(cw[1])), n);
                k = 1;
                while (!done[1] && k < 30) begin
                    step();
                    k++;
                end
                chk($sformatf("sweep %0d/%0d done latency", n, e), k, 10);
            end
        end

        // Random traffic, including occasional resets, checked cycle by cycle.
        for (int c = 0; c < 800; c++) begin
            for (int d = 0; d < 2; d++) begin
                dv[d]  = ($urandom_range(0, 2) == 0);
                din[d] = 4'($urandom);
                ep[d]  = 3'($urandom);
            end
            rst = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        for (int d = 0; d < 2; d++) dv[d] = 1'b0;
        for (int c = 0; c < 40; c++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/module_hamming_encoder_tx.md
Name: module_hamming_encoder_tx

Overview:
Hamming(7,4) encoder and serial transmitter. It is the send side of the existing Hamming error-correction path.
- Accepts a 4-bit data nibble over a valid/ready handshake and computes the 7-bit codeword.
- Optionally flips one codeword bit, chosen by switches, to exercise the decoder's correction logic.
- Shifts the frame out LSB-first on a single line, with start and stop bits, at a programmable bit period.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit period; legal range >= 1.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
data_in  input  4  data nibble {i3,i2,i1,i0}.
data_valid  input  1  data_in and err_pos are valid this cycle.
data_ready  output  1  block can accept a nibble this cycle.
err_pos  input  3  error injection: 0 = none; 1..7 flips codeword bit index (err_pos-1).
codeword  output  7  registered frame payload (after any injection), held until next acceptance.
tx_serial  output  1  serial line; idle high.
tx_busy  output  1  high while a frame is being sent (START/DATA/STOP).
tx_done  output  1  one-cycle pulse after the stop bit completes.

Behaviour:
- Codeword layout, index 6..0: {i3, i2, i1, p3, i0, p2, p1}.
- p1 = i0^i1^i3; p2 = i0^i2^i3; p3 = i1^i2^i3.
- A decoder syndrome {s2,s1,s0} of 011/101/110/111 points at i0/i1/i2/i3 respectively.
- Injection: codeword = clean ^ (1 << (err_pos-1)) when err_pos != 0; only one bit is ever flipped.
- Handshake:
  - Transfer occurs when data_valid && data_ready on a rising edge.
  - data_ready = (state == IDLE); combinational from state.
  - data_valid while not ready is ignored; no buffering.
  - data_in and err_pos are sampled only on the transfer cycle.
- The codeword register loads on the transfer cycle. It is visible the next cycle and stays stable until the next transfer.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_serial=1. On transfer go to START and clear the bit counter and baud counter.
  - START: tx_serial=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: tx_serial=codeword[bit_idx], starting at bit_idx 0. Each bit is held CLKS_PER_BIT cycles. After bit 6 go to STOP.
  - STOP: tx_serial=1 for CLKS_PER_BIT cycles, then go to IDLE and pulse tx_done for exactly one cycle (the first IDLE cycle).
- Frame length is 9*CLKS_PER_BIT cycles, from the cycle after the transfer through the last STOP cycle.
- Latency: the start bit appears on tx_serial in the cycle after the transfer cycle.
- tx_busy = state != IDLE.
- Back-to-back frames:
  - data_ready is high in the tx_done cycle, so a new transfer may be accepted there.
  - Minimum inter-frame gap is 1 idle-high cycle.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps. CLKS_PER_BIT=1 must give one-cycle bits. The bit counter is 3 bits and must not wrap past 6.
- Reset values: state=IDLE, tx_serial=1, codeword=0, tx_busy=0, tx_done=0, data_ready=1 after the reset cycle.
  - Reset mid-frame aborts the frame: tx_serial returns high the next cycle.
  - No tx_done is generated for an aborted frame, and codeword is cleared.
  - Reset overrides a simultaneous transfer.

Test Plan:
- Reset, CLKS_PER_BIT=4, data_in=4'b1011, err_pos=0, valid 1 cycle.
  - Response: codeword=7'b1010101. tx_serial frame is 0,1,0,1,0,1,0,1,1, each bit 4 cycles. tx_done pulses once, 37 cycles after the transfer.
- Encode all 16 nibbles, err_pos=0.
  - Response: 0000->7'b0000000, 0001->7'b0000111, 1111->7'b1111111.
  - For every nibble, the software syndrome is 000 and the decoded data equals the input.
- data_in=4'b1011, err_pos=3 -> codeword=7'b1010001; syndrome 011; corrected data=4'b1011.
- Sweep err_pos=1..7 for each nibble -> exactly one bit differs from clean. The syndrome equals err_pos; data bits correct when err_pos is 3, 5, 6 or 7.
- Hold data_valid high throughout with alternating data.
  - Response: data_ready low while busy; input changes mid-frame are ignored.
  - A new frame starts the cycle after tx_done, with a 1-cycle idle gap.
  - Repeat with CLKS_PER_BIT=1: frame is 9 cycles.
- Assert rst during DATA bit 3.
  - Response: next cycle tx_serial=1, tx_busy=0, codeword=0, no tx_done. A new transfer afterwards sends a full, correct frame.
